// File: rtl/imem_loader_if.sv
// imem_loader_if: load-request, byte-stream and instruction-memory write signals of the loader
interface imem_loader_if;
    logic        start_i;
    logic [15:0] len_i;
    logic        byte_valid_i;
    logic [7:0]  byte_i;
    logic        byte_ready_o;
    logic        imem_we_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_wdata_o;
    logic        core_rst_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    modport master (
        output start_i, len_i, byte_valid_i, byte_i,
        input  byte_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, core_rst_o, busy_o, done_o, err_o
    );
    modport slave (
        input  start_i, len_i, byte_valid_i, byte_i,
        output byte_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, core_rst_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into words and writes them to instruction memory
module imem_loader #(
    parameter int n = 20
) (
    input logic          clk,
    input logic          rst,
    imem_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RECV, WRITE, RUN} state_t;
    state_t      state;
    logic [15:0] len;
    logic [15:0] word_cnt;
    logic [1:0]  byte_cnt;
    logic [31:0] word;
    logic        len_zero;
    logic        len_bad;
    logic        last_word;
    assign len_zero  = bus.len_i == 16'd0;
    assign len_bad   = {16'd0, bus.len_i} > 32'(n);
    assign last_word = word_cnt == len - 16'd1;
    // single FSM; every output is a register updated together with the state transition
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            len              <= '0;
            word_cnt         <= '0;
            byte_cnt         <= '0;
            word             <= '0;
            bus.err_o        <= 1'b0;
            bus.done_o       <= 1'b0;
            bus.imem_we_o    <= 1'b0;
            bus.byte_ready_o <= 1'b0;
            bus.busy_o       <= 1'b0;
            bus.core_rst_o   <= 1'b1;
            bus.imem_addr_o  <= '0;
            bus.imem_wdata_o <= '0;
        end else begin
            bus.done_o    <= 1'b0;
            bus.imem_we_o <= 1'b0;
            case (state)
                IDLE, RUN: begin
                    if (bus.start_i && len_bad) begin
                        bus.err_o <= 1'b1;
                    end else if (bus.start_i) begin
                        bus.err_o        <= 1'b0;
                        len              <= bus.len_i;
                        word_cnt         <= '0;
                        byte_cnt         <= '0;
                        state            <= len_zero ? RUN : RECV;
                        bus.done_o       <= len_zero;
                        bus.core_rst_o   <= !len_zero;
                        bus.busy_o       <= !len_zero;
                        bus.byte_ready_o <= !len_zero;
                    end
                end
                RECV: begin
                    if (bus.byte_valid_i && bus.byte_ready_o) begin
                        word[{byte_cnt, 3'b000} +: 8] <= bus.byte_i;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state            <= WRITE;
                            bus.byte_ready_o <= 1'b0;
                            bus.imem_we_o    <= 1'b1;
                            bus.imem_addr_o  <= {14'd0, word_cnt, 2'b00};
                            bus.imem_wdata_o <= {bus.byte_i, word[23:0]};
                        end
                    end
                end
                WRITE: begin
                    word_cnt         <= word_cnt + 16'd1;
                    state            <= last_word ? RUN : RECV;
                    bus.done_o       <= last_word;
                    bus.core_rst_o   <= !last_word;
                    bus.busy_o       <= !last_word;
                    bus.byte_ready_o <= !last_word;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: vector table and directed sequences for imem_loader
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int drop_cnt = 0;
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    typedef struct {
        logic        s;
        logic [15:0] l;
        logic        v;
        logic [7:0]  b;
        logic [69:0] exp;
    } vec_t;
    vec_t tbl [12];
    imem_loader_if bus ();
    imem_loader #(.n(20)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // logs every write, done pulse and any ready drop while receiving
    always @(negedge clk) begin
        if (bus.imem_we_o) begin
            wr_addr[wr_cnt[5:0]] <= bus.imem_addr_o;
            wr_data[wr_cnt[5:0]] <= bus.imem_wdata_o;
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.done_o) done_cnt <= done_cnt + 1;
        if (bus.busy_o && !bus.imem_we_o && !bus.byte_ready_o) drop_cnt <= drop_cnt + 1;
    end
    function automatic logic [69:0] e(input logic r, w, c, bz, d, er, input logic [31:0] a, dt);
        return {r, w, c, bz, d, er, a, dt};
    endfunction
    function automatic logic [69:0] outs();
        return {bus.byte_ready_o, bus.imem_we_o, bus.core_rst_o, bus.busy_o, bus.done_o, bus.err_o,
                bus.imem_addr_o, bus.imem_wdata_o};
    endfunction
    function automatic vec_t mk(input logic s, input logic [15:0] l, input logic v, input logic [7:0] b,
                                input logic [69:0] x);
        return '{s, l, v, b, x};
    endfunction
    task automatic step(input logic s, input logic [15:0] l, input logic v, input logic [7:0] b);
        bus.start_i = s;
        bus.len_i = l;
        bus.byte_valid_i = v;
        bus.byte_i = b;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst = 1'b0;
    endtask
    task automatic send(input logic [31:0] w, input bit gap);
        int k;
        bit ph;
        logic acc;
        k = 0;
        ph = 1'b0;
        for (int t = 0; t < 40 && k < 4; t++) begin
            acc = !(gap && ph) && bus.byte_ready_o;
            step(1'b0, 16'd0, !(gap && ph), 8'(w >> (8 * k)));
            ph = !ph;
            if (acc) k++;
        end
        if (k < 4) chkw("send_timeout", k, 4);
    endtask
    initial begin
        int wb;
        int db;
        int xb;
        bus.start_i = 1'b0;
        bus.len_i = 16'd0;
        bus.byte_valid_i = 1'b0;
        bus.byte_i = 8'd0;
        do_reset();
        chk("reset", outs(), e(0, 0, 1, 0, 0, 0, 0, 0));
        tbl[0]  = mk(1, 2, 0, 8'h00, e(1, 0, 1, 1, 0, 0, 0, 0));
        tbl[1]  = mk(0, 0, 1, 8'h13, e(1, 0, 1, 1, 0, 0, 0, 0));
        tbl[2]  = mk(0, 0, 1, 8'h00, e(1, 0, 1, 1, 0, 0, 0, 0));
        tbl[3]  = mk(0, 0, 1, 8'h50, e(1, 0, 1, 1, 0, 0, 0, 0));
        tbl[4]  = mk(0, 0, 1, 8'h00, e(0, 1, 1, 1, 0, 0, 0, 32'h00500013));
        tbl[5]  = mk(0, 0, 1, 8'h93, e(1, 0, 1, 1, 0, 0, 0, 32'h00500013));
        tbl[6]  = mk(0, 0, 1, 8'h93, e(1, 0, 1, 1, 0, 0, 0, 32'h00500013));
        tbl[7]  = mk(0, 0, 1, 8'h00, e(1, 0, 1, 1, 0, 0, 0, 32'h00500013));
        tbl[8]  = mk(0, 0, 1, 8'h10, e(1, 0, 1, 1, 0, 0, 0, 32'h00500013));
        tbl[9]  = mk(0, 0, 1, 8'h00, e(0, 1, 1, 1, 0, 0, 4, 32'h00100093));
        tbl[10] = mk(0, 0, 0, 8'h00, e(0, 0, 0, 0, 1, 0, 4, 32'h00100093));
        tbl[11] = mk(0, 0, 0, 8'h00, e(0, 0, 0, 0, 0, 0, 4, 32'h00100093));
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].s, tbl[i].l, tbl[i].v, tbl[i].b);
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end
        do_reset();
        wb = wr_cnt;
        db = done_cnt;
        xb = drop_cnt;
        step(1, 2, 0, 0);
        send(32'h00500013, 1'b1);
        send(32'h00100093, 1'b1);
        repeat (3) step(0, 0, 0, 0);
        chkw("gap_writes", wr_cnt - wb, 2);
        chkw("gap_addr0", wr_addr[wb[5:0]], 32'h0);
        chkw("gap_data0", wr_data[wb[5:0]], 32'h00500013);
        chkw("gap_addr1", wr_addr[6'(wb + 1)], 32'h4);
        chkw("gap_data1", wr_data[6'(wb + 1)], 32'h00100093);
        chkw("gap_done", done_cnt - db, 1);
        chkw("gap_ready_drop", drop_cnt - xb, 0);
        chkw("gap_core_rst", 32'(bus.core_rst_o), 0);
        do_reset();
        wb = wr_cnt;
        step(1, 21, 0, 0);
        chkw("len21_err", 32'(bus.err_o), 1);
        chkw("len21_idle", 32'({bus.busy_o, bus.byte_ready_o, bus.core_rst_o}), 1);
        step(0, 0, 1, 8'hff);
        step(0, 0, 0, 0);
        chkw("len21_nowrite", wr_cnt - wb, 0);
        chkw("len21_sticky", 32'(bus.err_o), 1);
        step(1, 1, 0, 0);
        chkw("len1_err_clear", 32'(bus.err_o), 0);
        send(32'h44332211, 1'b0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chkw("len1_writes", wr_cnt - wb, 1);
        chkw("len1_addr", wr_addr[wb[5:0]], 32'h0);
        chkw("len1_data", wr_data[wb[5:0]], 32'h44332211);
        step(1, 20, 0, 0);
        chkw("len20_accept", 32'({bus.busy_o, bus.err_o}), 2);
        do_reset();
        wb = wr_cnt;
        step(1, 0, 0, 0);
        chk("len0_run", outs(), e(0, 0, 0, 0, 1, 0, 0, 0));
        step(0, 0, 0, 0);
        chk("len0_done_once", outs(), e(0, 0, 0, 0, 0, 0, 0, 0));
        chkw("len0_nowrite", wr_cnt - wb, 0);
        do_reset();
        wb = wr_cnt;
        step(1, 2, 0, 0);
        step(0, 0, 1, 8'haa);
        step(0, 0, 1, 8'hbb);
        rst = 1'b1;
        step(0, 0, 1, 8'hcc);
        rst = 1'b0;
        chk("rst_mid_state", outs(), e(0, 0, 1, 0, 0, 0, 0, 0));
        step(0, 0, 1, 8'hdd);
        step(0, 0, 1, 8'hee);
        step(0, 0, 1, 8'hff);
        step(0, 0, 1, 8'h11);
        step(0, 0, 0, 0);
        chkw("rst_mid_nowrite", wr_cnt - wb, 0);
        chk("rst_mid_idle", outs(), e(0, 0, 1, 0, 0, 0, 0, 0));
        step(1, 1, 0, 0);
        send(32'hcafef00d, 1'b0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chkw("reload_writes", wr_cnt - wb, 1);
        chkw("reload_addr", wr_addr[wb[5:0]], 32'h0);
        chkw("reload_data", wr_data[wb[5:0]], 32'hcafef00d);
        chkw("reload_run", 32'(bus.core_rst_o), 0);
        wb = wr_cnt;
        db = done_cnt;
        step(1, 1, 0, 0);
        chkw("rerun_core_rst", 32'({bus.core_rst_o, bus.busy_o}), 3);
        step(0, 0, 1, 8'h01);
        step(1, 0, 0, 8'h00);
        step(1, 30, 0, 8'h00);
        chk("recv_start_ignored", outs(), e(1, 0, 1, 1, 0, 0, 0, 32'hcafef00d));
        step(0, 0, 1, 8'h02);
        step(0, 0, 1, 8'h03);
        step(0, 0, 1, 8'h04);
        chk("rerun_write", outs(), e(0, 1, 1, 1, 0, 0, 0, 32'h04030201));
        step(0, 0, 0, 0);
        chk("rerun_done", outs(), e(0, 0, 0, 0, 1, 0, 0, 32'h04030201));
        step(0, 0, 0, 0);
        chkw("rerun_writes", wr_cnt - wb, 1);
        chkw("rerun_done_cnt", done_cnt - db, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: n, default 20, instruction-memory depth in 32-bit words (same meaning as the imem depth parameter).
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start_i  input  1  load request; sampled only in IDLE or RUN.
REQ-005 len_i  input  16  number of words to load; latched on accepted start_i.
REQ-006 byte_valid_i  input  1  source has a program byte on byte_i.
REQ-007 byte_i  input  8  program byte, little-endian within each word.
REQ-008 byte_ready_o  output  1  loader accepts a byte this cycle.
REQ-009 imem_we_o  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 imem_addr_o  output  32  byte address of the word being written.
REQ-011 imem_wdata_o  output  32  assembled instruction word.
REQ-012 core_rst_o  output  1  holds the processor core in reset while high.
REQ-013 busy_o  output  1  high in RECV and WRITE.
REQ-014 done_o  output  1  one-cycle pulse on load completion.
REQ-015 err_o  output  1  sticky length-error flag.

Function
REQ-016 FSM states SHALL be IDLE, RECV, WRITE, RUN; all outputs SHALL be decoded from registered state and registers only (no combinational path from inputs to outputs).
REQ-017 IDLE: core_rst_o=1, byte_ready_o=0; start_i with 1<=len_i<=n SHALL latch len_i, clear word and byte counters, go to RECV.
REQ-018 Any state: start_i accepted with len_i==0 SHALL go to RUN and pulse done_o in the first RUN cycle, with no memory writes.
REQ-019 start_i with len_i>n SHALL set err_o, leave state unchanged and perform no writes; err_o SHALL clear only on rst or on a subsequent accepted valid start_i.
REQ-020 RECV: byte_ready_o=1; a byte SHALL be accepted only on a cycle with byte_valid_i && byte_ready_o.
REQ-021 Byte k (k=0..3) of a word SHALL be stored in bits [8k+7:8k] of the word register; the 2-bit byte counter SHALL wrap 3->0.
REQ-022 Acceptance of byte 3 SHALL move to WRITE on the next edge; byte_ready_o SHALL be 0 in WRITE.
REQ-023 WRITE lasts exactly one cycle: imem_we_o=1, imem_addr_o={word_cnt,2'b00} zero-extended to 32 bits, imem_wdata_o=assembled word.
REQ-024 After WRITE: word_cnt SHALL increment; if the written word was word len-1, go to RUN; otherwise return to RECV.
REQ-025 done_o SHALL be 1 for exactly the first cycle in RUN after a completed load, else 0.
REQ-026 RUN: core_rst_o=0, busy_o=0; core_rst_o SHALL be 1 in every other state.
REQ-027 start_i in RECV or WRITE SHALL be ignored (no relatch, no err_o update).
REQ-028 start_i accepted in RUN SHALL reassert core_rst_o on the next cycle and restart a load from address 0.
REQ-029 imem_we_o SHALL be 0 outside WRITE; imem_addr_o/imem_wdata_o are don't-care when imem_we_o=0 but SHALL hold last values (no X).
REQ-030 Throughput: with byte_valid_i held high, one word SHALL be written every 5 cycles.

Reset
REQ-031 rst high at a rising edge SHALL force IDLE, word_cnt=0, byte counter=0, word register=0, err_o=0, done_o=0, imem_we_o=0, byte_ready_o=0, busy_o=0, core_rst_o=1, imem_addr_o=0, imem_wdata_o=0.
REQ-032 rst asserted mid-load (RECV or WRITE) SHALL abandon the partial word without a write; no load resumes until a new start_i.

Verification
REQ-033 Reset, then start_i with len_i=2, bytes 13,00,50,00,93,00,10,00 back-to-back -> writes 0x00500013 @0x0, 0x00100093 @0x4; done_o pulses once; core_rst_o falls at the done_o cycle; total 10 cycles from first byte to RUN.
REQ-034 Same load with byte_valid_i low every other cycle -> identical writes and data, byte_ready_o never drops in RECV, no extra writes.
REQ-035 start_i with len_i=21 (n=20) -> err_o=1, state IDLE, no writes; then start_i with len_i=1 -> err_o=0, load proceeds.
REQ-036 start_i with len_i=0 -> RUN next cycle, done_o=1 one cycle, imem_we_o never asserted.
REQ-037 rst pulsed after 2 bytes of word 1 -> no write, core_rst_o=1, IDLE; new start_i with len_i=1 writes its word at address 0x0.
REQ-038 In RUN, start_i with len_i=1 -> core_rst_o=1 next cycle; start_i pulsed during RECV ignored; word written at 0x0, done_o pulses again.
